// File: rtl/dmem_param.sv
// dmem_param: parametrised single-port data memory with a valid/ready request
// port and a registered one-cycle response. After reset or a soft clear, a
// hardware sweep writes zero to every word before requests are accepted.
// Optional feature: define DMEM_BOUNDS_CHECK_EN to flag out-of-range
// addresses (rsp_err = 1, rsp_rdata = 0, writes dropped). Without it, the
// upper address bits are ignored and the address wraps modulo DEPTH.
//
// state | meaning
// ------+---------------------------------------------------------------
// INIT  | zero-fill sweep in progress, one word per cycle; req_ready = 0
// RUN   | memory usable; requests accepted every cycle

module dmem_param #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int LANES = DATA_W / 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t           state, state_nxt;
    logic [IDX_W-1:0] clr_idx, clr_idx_nxt;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [IDX_W-1:0]  idx;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] merged;
    logic              accept;
    logic              addr_oob;
    logic              wr_en;

    assign idx       = req_addr[IDX_W-1:0];
    assign rd_word   = mem[idx];
    assign req_ready = (state == RUN);
    assign init_done = (state == RUN);
    assign accept    = req_valid && req_ready;

`ifdef DMEM_BOUNDS_CHECK_EN
    generate
        if (ADDR_W > IDX_W) begin : g_addr_hi
            assign addr_oob = |req_addr[ADDR_W-1:IDX_W];
        end else begin : g_addr_full
            assign addr_oob = 1'b0;
        end
    endgenerate
`else
    // Upper address bits are intentionally ignored so the address wraps.
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr;
    assign addr_oob = 1'b0;
`endif

    assign wr_en = accept && req_we && !addr_oob;

    // Merge write data into the current word lane by lane.
    always_comb begin
        merged = rd_word;
        for (int i = 0; i < LANES; i++) begin
            if (req_be[i]) merged[8*i +: 8] = req_wdata[8*i +: 8];
        end
    end

    // State register and sweep counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= INIT;
            clr_idx <= '0;
        end else begin
            state   <= state_nxt;
            clr_idx <= clr_idx_nxt;
        end
    end

    // Next-state logic: sweep all words, then run until a soft clear.
    always_comb begin
        state_nxt   = state;
        clr_idx_nxt = clr_idx;
        case (state)
            INIT: begin
                if (clear) begin
                    clr_idx_nxt = '0;
                end else if (clr_idx == LAST_IDX) begin
                    state_nxt   = RUN;
                    clr_idx_nxt = '0;
                end else begin
                    clr_idx_nxt = clr_idx + 1'b1;
                end
            end
            RUN: begin
                if (clear) begin
                    state_nxt   = INIT;
                    clr_idx_nxt = '0;
                end
            end
            default: begin
                state_nxt   = INIT;
                clr_idx_nxt = '0;
            end
        endcase
    end

    // Memory array: zero-fill during the sweep, lane writes while running.
    always_ff @(posedge clk) begin
        if (state == INIT) begin
            mem[clr_idx] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < LANES; i++) begin
                if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
            end
        end
    end

    // Response strobe and data; data holds between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= accept;
            if (accept) begin
                if (addr_oob) rsp_rdata <= '0;
                else          rsp_rdata <= req_we ? merged : rd_word;
            end
        end
    end

`ifdef DMEM_BOUNDS_CHECK_EN
    // Error flag follows each accepted request's range check.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      rsp_err <= 1'b0;
        else if (accept) rsp_err <= addr_oob;
    end
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_param.sv
// Directed bench for dmem_param (DATA_W=16, DEPTH=8, ADDR_W=16).
module tb_dmem_param;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic [1:0]  req_be;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic        init_done;

    int checks   = 0;
    int failures = 0;

    dmem_param #(.DATA_W(16), .DEPTH(8), .ADDR_W(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Ready must stay low for 7 more edges, then rise on the 8th.
    task automatic wait_sweep(input string tag);
        for (int k = 1; k < 8; k++) begin
            tick();
            chk({tag, "_ready_low"}, {31'd0, req_ready}, 32'd0);
        end
        tick();
        chk({tag, "_ready_high"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_init_done"}, {31'd0, init_done}, 32'd1);
    endtask

    task automatic do_req(input string tag, input logic we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be,
                          input logic [15:0] exp_data, input logic exp_err);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        tick();
        req_valid = 1'b0;
        chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
        chk({tag, "_data"}, {16'd0, rsp_rdata}, {16'd0, exp_data});
        chk({tag, "_err"}, {31'd0, rsp_err}, {31'd0, exp_err});
    endtask

    logic exp_oob_err;
    logic [15:0] exp_oob_data;
    logic [15:0] exp_addr1;

    initial begin
`ifdef DMEM_BOUNDS_CHECK_EN
        exp_oob_err  = 1'b1;
        exp_oob_data = 16'h0000;
        exp_addr1    = 16'h1111;
`else
        exp_oob_err  = 1'b0;
        exp_oob_data = 16'h5555;
        exp_addr1    = 16'h5555;
`endif
        rst_n = 1'b0; clear = 1'b0; req_valid = 1'b0; req_we = 1'b0;
        req_addr = '0; req_wdata = '0; req_be = '0;
        tick(); tick();
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_init_done", {31'd0, init_done}, 32'd0);

        rst_n = 1'b1;
        chk("rel_ready_low0", {31'd0, req_ready}, 32'd0);
        wait_sweep("rel");
        for (int a = 0; a < 8; a++) do_req("init_rd", 1'b0, 16'(a), 16'hFFFF, 2'b11, 16'h0000, 1'b0);

        // write then back-to-back read of the same word
        do_req("wr3", 1'b1, 16'd3, 16'hBEEF, 2'b11, 16'hBEEF, 1'b0);
        do_req("rd3", 1'b0, 16'd3, 16'h0000, 2'b00, 16'hBEEF, 1'b0);
        tick();
        chk("idle_valid", {31'd0, rsp_valid}, 32'd0);
        chk("idle_hold", {16'd0, rsp_rdata}, 32'hBEEF);

        // byte lanes
        do_req("wr5_full", 1'b1, 16'd5, 16'h1234, 2'b11, 16'h1234, 1'b0);
        do_req("wr5_hi", 1'b1, 16'd5, 16'hABCD, 2'b10, 16'hAB34, 1'b0);
        do_req("rd5", 1'b0, 16'd5, 16'h0000, 2'b00, 16'hAB34, 1'b0);
        do_req("wr5_lo", 1'b1, 16'd5, 16'h00EE, 2'b01, 16'hABEE, 1'b0);
        do_req("wr5_none", 1'b1, 16'd5, 16'hFFFF, 2'b00, 16'hABEE, 1'b0);
        do_req("rd5_b", 1'b0, 16'd5, 16'h0000, 2'b11, 16'hABEE, 1'b0);

        // out-of-range address
        do_req("wr1", 1'b1, 16'd1, 16'h1111, 2'b11, 16'h1111, 1'b0);
        do_req("wr9", 1'b1, 16'd9, 16'h5555, 2'b11, exp_oob_data, exp_oob_err);
        do_req("rd1", 1'b0, 16'd1, 16'h0000, 2'b00, exp_addr1, 1'b0);

        // read accepted on the clear edge still responds
        clear = 1'b1;
        do_req("clr_rd5", 1'b0, 16'd5, 16'h0000, 2'b00, 16'hABEE, 1'b0);
        clear = 1'b0;
        chk("clr_ready_low0", {31'd0, req_ready}, 32'd0);
        chk("clr_init_done", {31'd0, init_done}, 32'd0);
        wait_sweep("clr");
        for (int a = 0; a < 8; a++) do_req("clr_rd", 1'b0, 16'(a), 16'h0000, 2'b00, 16'h0000, 1'b0);

        // reset in the middle of a sweep
        do_req("wr6", 1'b1, 16'd6, 16'h6666, 2'b11, 16'h6666, 1'b0);
        do_req("wr2", 1'b1, 16'd2, 16'h7777, 2'b11, 16'h7777, 1'b0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        chk("mid_hold", {16'd0, rsp_rdata}, 32'h7777);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd0);
        chk("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
        chk("mid_rst_rdata", {16'd0, rsp_rdata}, 32'd0);
        chk("mid_rst_err", {31'd0, rsp_err}, 32'd0);
        chk("mid_rst_done", {31'd0, init_done}, 32'd0);
        tick();
        rst_n = 1'b1;
        wait_sweep("rerun");
        for (int a = 0; a < 8; a++) do_req("rerun_rd", 1'b0, 16'(a), 16'h0000, 2'b00, 16'h0000, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
